// File: rtl/booth_divider_module_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand width and the quotient reported on divide by zero.
package booth_divider_module_pkg;

  localparam int DIV_WIDTH = 8;

  // Controller states; the numeric encoding is fixed so it stays stable in
  // waveforms and in any debug tooling that decodes the state register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } div_state_t;

  // Quotient reported when the divisor is zero (-1 at the default width).
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/booth_divider_module_step.sv
// One radix-2 restoring division step on unsigned magnitudes. The partial
// remainder carries one extra bit so the sign of the trial subtraction is
// never lost, even for a divisor magnitude of 2^(WIDTH-1).
module booth_divider_step_module
  import booth_divider_module_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [2*WIDTH:0] shifted_pair_s;
  logic [WIDTH:0]   shifted_rem_s;
  logic [WIDTH-1:0] shifted_q_s;
  logic [WIDTH:0]   trial_s;

  // Shift {rem, q} left, trial-subtract the divisor and restore on borrow
  always_comb begin
    shifted_pair_s = {rem, q} << 1;
    shifted_rem_s  = shifted_pair_s[2*WIDTH:WIDTH];
    shifted_q_s    = shifted_pair_s[WIDTH-1:0];
    trial_s        = shifted_rem_s - {1'b0, div};
    rem_next       = shifted_rem_s;
    q_next         = shifted_q_s;
    if (trial_s[WIDTH] == 1'b0) begin
      rem_next = trial_s;
      q_next   = {shifted_q_s[WIDTH-1:1], 1'b1};
    end else begin
      rem_next = shifted_rem_s;
      q_next   = {shifted_q_s[WIDTH-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/booth_divider_module.sv
// Sequential signed divider: captures operands on start_i, converts them to
// magnitudes, runs WIDTH restoring steps (one per clock), then restores the
// signs. Quotient truncates toward zero; remainder follows the dividend sign.
module booth_divider_module
  import booth_divider_module_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{1'b1}};

  div_state_t       state_r;
  div_state_t       state_s;

  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] mag_b_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   rem_r;
  logic [CW-1:0]    cnt_r;
  logic             sq_r;
  logic             sr_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_zero_r;

  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             div_zero_s;
  logic [WIDTH:0]   step_rem_s;
  logic [WIDTH-1:0] step_q_s;

  // Two's-complement negation at operand width; -2^(WIDTH-1) maps to itself,
  // which is exactly the magnitude encoding wanted for the most negative value.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  booth_divider_step_module #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .div      (mag_b_r),
    .rem_next (step_rem_s),
    .q_next   (step_q_s)
  );

  // Operand magnitudes and the divide-by-zero flag from the captured operands
  always_comb begin
    mag_a_s    = dividend_r;
    mag_b_s    = divisor_r;
    div_zero_s = (divisor_r == {WIDTH{1'b0}});
    if (dividend_r[WIDTH-1]) begin
      mag_a_s = twos_neg(dividend_r);
    end else begin
      mag_a_s = dividend_r;
    end
    if (divisor_r[WIDTH-1]) begin
      mag_b_s = twos_neg(divisor_r);
    end else begin
      mag_b_s = divisor_r;
    end
  end

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: IDLE -> LOAD -> CALC (WIDTH steps) -> FIX -> IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_CALC;
      ST_CALC: begin
        if (cnt_r == LAST_STEP) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: capture, magnitude load, iteration and sign fix-up of results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_r  <= {WIDTH{1'b0}};
      divisor_r   <= {WIDTH{1'b0}};
      mag_b_r     <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      cnt_r       <= {CW{1'b0}};
      sq_r        <= 1'b0;
      sr_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      div_zero_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            dividend_r <= dividend_i;
            divisor_r  <= divisor_i;
          end
        end
        ST_LOAD: begin
          q_r     <= mag_a_s;
          mag_b_r <= mag_b_s;
          rem_r   <= {(WIDTH+1){1'b0}};
          cnt_r   <= {CW{1'b0}};
          sq_r    <= dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1];
          sr_r    <= dividend_r[WIDTH-1];
        end
        ST_CALC: begin
          rem_r <= step_rem_s;
          q_r   <= step_q_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_FIX: begin
          done_r <= 1'b1;
          if (div_zero_s) begin
            // Latency is kept uniform; the iteration result is discarded.
            quotient_r  <= ZERO_QUOT;
            remainder_r <= dividend_r;
            div_zero_r  <= 1'b1;
          end else begin
            quotient_r  <= sq_r ? twos_neg(q_r) : q_r;
            remainder_r <= sr_r ? twos_neg(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
            div_zero_r  <= 1'b0;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign quotient_o  = quotient_r;
  assign remainder_o = remainder_r;
  assign div_zero_o  = div_zero_r;

endmodule

// File: tb/tb_booth_divider_module.sv
// Scoreboard bench for booth_divider_module: the driver pushes the expected
// result of every accepted division, a forked monitor pops and compares on
// each done_o pulse.
module tb_booth_divider_module;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_zero_o;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  booth_divider_module #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: signed integer division truncating toward zero, remainder with
  // the dividend's sign, fixed (-1, dividend, flag) answer for divisor zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.acc = acc;
    if (sb == 0) begin
      e.q  = 8'hFF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = 8'(sa / sb);
      e.r  = 8'(sa % sb);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Start one division, hold start for a single cycle and wait for done_o.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int busy_cnt;
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    exp_q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        busy_cnt += int'(busy_o);
        @(negedge clk);
      end
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("busy_cycles", busy_cnt, W + 2);
      chk("busy_at_done", int'(busy_o), 0);
    end
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Monitor: compare every done_o pulse against the scoreboard head.
    fork
      begin
        logic prev_done;
        exp_t m;
        prev_done = 1'b0;
        forever begin
          @(negedge clk);
          if (done_o) begin
            chk("done_pulse_width", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: q=%h r=%h dz=%b with nothing outstanding",
                       quotient_o, remainder_o, div_zero_o);
            end else begin
              m = exp_q.pop_front();
              checks++;
              if (quotient_o !== m.q || remainder_o !== m.r || div_zero_o !== m.dz) begin
                errors++;
                $display("FAIL result: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                         quotient_o, remainder_o, div_zero_o, m.q, m.r, m.dz);
              end
              chk("latency", cyc - m.acc, W + 2);
            end
          end
          prev_done = done_o;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_quot", int'(quotient_o), 0);
    chk("rst_rem", int'(remainder_o), 0);
    chk("rst_dz", int'(div_zero_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases: signs, overflow, divide by zero and recovery
    issue(8'd100, 8'd7);
    issue(8'(-100), 8'd7);
    issue(8'd100, 8'(-7));
    issue(8'(-100), 8'(-7));
    issue(8'h80, 8'hFF);
    issue(8'h80, 8'd1);
    issue(8'd37, 8'd0);
    repeat (2) @(negedge clk);
    chk("dz_held", int'(div_zero_o), 1);
    chk("quot_held", int'(quotient_o), 8'hFF);
    issue(8'd6, 8'd3);
    @(negedge clk);

    // start_i held high with operands changing every cycle: only the values
    // present at the acceptance edges (every W+3 cycles) are used.
    for (int n = 0; n < 2 * (W + 3) + 1; n++) begin
      dividend_i = 8'($urandom);
      divisor_i  = 8'($urandom);
      start_i    = 1'b1;
      if (n % (W + 3) == 0) exp_q.push_back(model(dividend_i, divisor_i, cyc + 1));
      @(negedge clk);
    end
    start_i = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("held_start_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a division aborts it without a done pulse
    dividend_i = 8'd50;
    divisor_i  = 8'd5;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_busy", int'(busy_o), 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_quot", int'(quotient_o), 0);
    chk("abort_rem", int'(remainder_o), 0);
    chk("abort_dz", int'(div_zero_o), 0);
    #2 rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_idle", int'(busy_o), 0);
    issue(8'd20, 8'd6);

    // Randomized divisions with biased corner operands
    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 8'd0;
        1: rb = 8'hFF;
        2: ra = 8'h80;
        3: rb = 8'h80;
        default: ;
      endcase
      issue(ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
